// File: rtl/control_unit_fsm.sv
// Multi-cycle controller: sequences fetch/decode/execute/writeback and drives
// the datapath load and select strobes from the latched opcode.
module control_unit_fsm #(
    parameter int FETCH_WAIT = 0,
    parameter int ALU_LAT    = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Go,
    input  logic [3:0] IRCU,
    output logic       Aload,
    output logic       Bload,
    output logic       IRload,
    output logic       PCload,
    output logic       ANSload,
    output logic [1:0] JSM,
    output logic [1:0] select_mode,
    output logic [3:0] mode,
    output logic       Busy,
    output logic       Halted,
    output logic [2:0] State
);

    localparam int MAX_WAIT = (FETCH_WAIT > ALU_LAT) ? FETCH_WAIT : ALU_LAT;
    localparam int CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_WAIT);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(ALU_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic [3:0]       op_r;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_r  <= 4'h0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (state == S_DECODE) begin
                op_r <= IRCU;
            end
        end
    end

    // The counter only advances while a multi-cycle state holds; any exit clears it.
    always_comb begin
        next_state  = state;
        next_cnt    = '0;
        Aload       = 1'b0;
        Bload       = 1'b0;
        IRload      = 1'b0;
        PCload      = 1'b0;
        ANSload     = 1'b0;
        JSM         = 2'd0;
        select_mode = 2'd0;
        mode        = 4'h0;
        case (state)
            S_IDLE: begin
                if (Go) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (cnt == FETCH_LAST) begin
                    IRload     = 1'b1;
                    PCload     = 1'b1;
                    next_state = S_DECODE;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                next_state = S_EXEC;
            end
            S_EXEC: begin
                case (op_r)
                    4'h0: next_state = S_FETCH;
                    4'h1: begin
                        Aload       = 1'b1;
                        select_mode = 2'd1;
                        next_state  = S_FETCH;
                    end
                    4'h2: begin
                        Bload       = 1'b1;
                        select_mode = 2'd2;
                        next_state  = S_FETCH;
                    end
                    4'h3: begin
                        PCload     = 1'b1;
                        JSM        = 2'd1;
                        next_state = S_FETCH;
                    end
                    4'hF: next_state = S_HALT;
                    default: begin
                        mode = op_r;
                        if (cnt == EXEC_LAST) begin
                            next_state = S_WB;
                        end else begin
                            next_cnt = cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
            S_WB: begin
                ANSload    = 1'b1;
                mode       = op_r;
                next_state = S_FETCH;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign Busy   = (state != S_IDLE) && (state != S_HALT);
    assign Halted = (state == S_HALT);
    assign State  = state;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Randomised bench for control_unit_fsm: two configurations are checked cycle by
// cycle against per-instruction output sequences built from the opcode rules.
module tb_control_unit_fsm;

    logic       clk = 1'b0;
    logic [1:0] rst_n = 2'b00;
    logic [1:0] go = 2'b00;
    logic [3:0] ircu [2];

    logic [17:0] obs [2];
    logic [17:0] q [$];
    int total = 0;
    int bad = 0;

    localparam int FW0 = 0;
    localparam int AL0 = 1;
    localparam int FW1 = 2;
    localparam int AL1 = 3;

    localparam int ST_A   = 16;
    localparam int ST_B   = 8;
    localparam int ST_IR  = 4;
    localparam int ST_PC  = 2;
    localparam int ST_ANS = 1;

    always #5 clk = ~clk;

    logic       a0, b0, ir0, pc0, ans0, busy0, halt0;
    logic [1:0] jsm0, sm0;
    logic [3:0] md0;
    logic [2:0] st0;
    logic       a1, b1, ir1, pc1, ans1, busy1, halt1;
    logic [1:0] jsm1, sm1;
    logic [3:0] md1;
    logic [2:0] st1;

    control_unit_fsm #(.FETCH_WAIT(FW0), .ALU_LAT(AL0)) dut0 (
        .Clk(clk), .Reset(rst_n[0]), .Go(go[0]), .IRCU(ircu[0]),
        .Aload(a0), .Bload(b0), .IRload(ir0), .PCload(pc0), .ANSload(ans0),
        .JSM(jsm0), .select_mode(sm0), .mode(md0),
        .Busy(busy0), .Halted(halt0), .State(st0)
    );

    control_unit_fsm #(.FETCH_WAIT(FW1), .ALU_LAT(AL1)) dut1 (
        .Clk(clk), .Reset(rst_n[1]), .Go(go[1]), .IRCU(ircu[1]),
        .Aload(a1), .Bload(b1), .IRload(ir1), .PCload(pc1), .ANSload(ans1),
        .JSM(jsm1), .select_mode(sm1), .mode(md1),
        .Busy(busy1), .Halted(halt1), .State(st1)
    );

    assign obs[0] = {st0, busy0, halt0, a0, b0, ir0, pc0, ans0, jsm0, sm0, md0};
    assign obs[1] = {st1, busy1, halt1, a1, b1, ir1, pc1, ans1, jsm1, sm1, md1};

    // Expected output word for one cycle; Busy/Halted follow from the state code.
    function automatic logic [17:0] vec(input int st, input int strobes,
                                        input int jsm, input int sm, input int md);
        logic busy;
        logic halted;
        busy   = (st != 0) && (st != 5);
        halted = (st == 5);
        return {3'(st), busy, halted, 5'(strobes), 2'(jsm), 2'(sm), 4'(md)};
    endfunction

    // Per-instruction expected cycle sequence, starting at its first FETCH cycle.
    task automatic expand(input int fw, input int al, input logic [3:0] op);
        q.delete();
        for (int i = 0; i < fw; i++) q.push_back(vec(1, 0, 0, 0, 0));
        q.push_back(vec(1, ST_IR + ST_PC, 0, 0, 0));
        q.push_back(vec(2, 0, 0, 0, 0));
        case (op)
            4'h0: q.push_back(vec(3, 0, 0, 0, 0));
            4'h1: q.push_back(vec(3, ST_A, 0, 1, 0));
            4'h2: q.push_back(vec(3, ST_B, 0, 2, 0));
            4'h3: q.push_back(vec(3, ST_PC, 1, 0, 0));
            4'hF: q.push_back(vec(3, 0, 0, 0, 0));
            default: begin
                for (int i = 0; i < al; i++) q.push_back(vec(3, 0, 0, 0, int'(op)));
                q.push_back(vec(4, ST_ANS, 0, 0, int'(op)));
            end
        endcase
    endtask

    task automatic applyStimulus(input int sel, input logic g, input logic [3:0] ir,
                                 input logic r);
        go[sel]    = g;
        ircu[sel]  = ir;
        rst_n[sel] = r;
    endtask

    task automatic checkOutput(input int sel, input string tag, input logic [17:0] expv);
        total++;
        assert (obs[sel] === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s dut%0d observed=%h expected=%h", tag, sel, obs[sel], expv);
        end
    endtask

    task automatic resetCycle(input int sel, input string tag);
        applyStimulus(sel, 1'b0, 4'($urandom), 1'b0);
        @(negedge clk);
        checkOutput(sel, tag, vec(0, 0, 0, 0, 0));
        applyStimulus(sel, 1'b0, 4'($urandom), 1'b1);
    endtask

    task automatic startRun(input int sel);
        checkOutput(sel, "idle_before_go", vec(0, 0, 0, 0, 0));
        applyStimulus(sel, 1'b1, 4'($urandom), 1'b1);
        @(negedge clk);
    endtask

    // abort_at: -1 runs to completion, -2 resets at a random cycle, else at that index.
    task automatic runInstr(input int sel, input logic [3:0] op, input int abort_at);
        int fw;
        int al;
        int stop;
        fw = (sel == 0) ? FW0 : FW1;
        al = (sel == 0) ? AL0 : AL1;
        expand(fw, al, op);
        stop = (abort_at == -2) ? int'($urandom_range(0, q.size() - 1)) : abort_at;
        for (int i = 0; i < q.size(); i++) begin
            checkOutput(sel, $sformatf("op%h_cyc%0d", op, i), q[i]);
            if (i == stop) begin
                resetCycle(sel, $sformatf("reset_mid_op%h_cyc%0d", op, i));
                return;
            end
            if (q[i][17:15] == 3'd2) begin
                applyStimulus(sel, 1'($urandom), op, 1'b1);
            end else begin
                applyStimulus(sel, 1'($urandom), 4'($urandom), 1'b1);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0] directed [5];
        logic [3:0] op;
        directed[0] = 4'h1;
        directed[1] = 4'h6;
        directed[2] = 4'h3;
        directed[3] = 4'h0;
        directed[4] = 4'h2;
        ircu[0] = 4'h0;
        ircu[1] = 4'h0;
        @(negedge clk);
        for (int sel = 0; sel < 2; sel++) begin
            $display("[TB] exercising dut%0d", sel);
            resetCycle(sel, "reset_initial");
            for (int i = 0; i < 2; i++) begin
                checkOutput(sel, "idle_no_go", vec(0, 0, 0, 0, 0));
                applyStimulus(sel, 1'b0, 4'($urandom), 1'b1);
                @(negedge clk);
            end
            startRun(sel);
            for (int i = 0; i < 5; i++) runInstr(sel, directed[i], -1);
            for (int i = 0; i < 20; i++) begin
                op = 4'($urandom_range(0, 14));
                runInstr(sel, op, -1);
            end
            runInstr(sel, 4'hF, -1);
            for (int i = 0; i < 10; i++) begin
                checkOutput(sel, "halt_hold", vec(5, 0, 0, 0, 0));
                applyStimulus(sel, 1'b1, 4'($urandom), 1'b1);
                @(negedge clk);
            end
            checkOutput(sel, "halt_after_go", vec(5, 0, 0, 0, 0));
            resetCycle(sel, "reset_from_halt");
            startRun(sel);
            runInstr(sel, 4'h6, (sel == 0) ? FW0 + 2 + AL0 : FW1 + 2 + AL1);
            for (int i = 0; i < 4; i++) begin
                startRun(sel);
                op = 4'($urandom);
                runInstr(sel, op, -2);
            end
            applyStimulus(sel, 1'b0, 4'h0, 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
